// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FULL} arb_st_t;

  localparam int MAX_REQ = 16;

  // Index arithmetic that wraps modulo n; a < n and b <= n are assumed.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

  function automatic logic [3:0] oh2idx(input logic [MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant_i, wrapping.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int SRC_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SRC_W-1:0]   idx_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_i[wrap_add(int'(last_grant_i), k, NUM_REQ)]) begin
        grant_o[wrap_add(int'(last_grant_i), k, NUM_REQ)] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign idx_o = SRC_W'(oh2idx(MAX_REQ'(grant_o)));

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among NUM_REQ requesters.
// Define ARB_PKT_LOCK_EN to hold the grant on a requester until its s_last beat.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 8,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WORD_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [SRC_W-1:0]              m_src
);

  arb_st_t               state_q, state_d;
  logic                  acc_en_q, acc_en_d;
  logic                  valid_q, valid_d;
  logic [SRC_W-1:0]      last_grant_q, last_grant_d;
  logic [WORD_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                  main_last_q, main_last_d, skid_last_q, skid_last_d;
  logic [SRC_W-1:0]      main_src_q, main_src_d, skid_src_q, skid_src_d;

  logic [NUM_REQ-1:0]    pick_grant, grant;
  logic [SRC_W-1:0]      pick_idx, grant_idx;
  logic                  accept;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_last;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i       (s_valid),
    .last_grant_i(last_grant_q),
    .grant_o     (pick_grant),
    .idx_o       (pick_idx)
  );

`ifdef ARB_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [SRC_W-1:0] lock_idx_q, lock_idx_d;

  // A locked packet owns the channel even while its requester is idle.
  always_comb begin
    if (lock_q) begin
      grant     = s_valid[lock_idx_q] ? (NUM_REQ'(1) << lock_idx_q) : '0;
      grant_idx = lock_idx_q;
    end else begin
      grant     = pick_grant;
      grant_idx = pick_idx;
    end
  end
`else
  assign grant     = pick_grant;
  assign grant_idx = pick_idx;
`endif

  assign s_ready = grant & {NUM_REQ{acc_en_q & rstn}};
  assign accept  = |(s_valid & s_ready);
  assign in_data = s_data[grant_idx*WORD_WIDTH +: WORD_WIDTH];
  assign in_last = s_last[grant_idx];

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    main_src_d  = main_src_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_src_d  = skid_src_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = BUSY;
          main_data_d = in_data;
          main_last_d = in_last;
          main_src_d  = grant_idx;
        end
      end
      BUSY: begin
        if (accept && m_ready) begin
          main_data_d = in_data;
          main_last_d = in_last;
          main_src_d  = grant_idx;
        end else if (accept) begin
          state_d     = FULL;
          skid_data_d = in_data;
          skid_last_d = in_last;
          skid_src_d  = grant_idx;
        end else if (m_ready) begin
          state_d = IDLE;
        end
      end
      FULL: begin
        if (m_ready) begin
          state_d     = BUSY;
          main_data_d = skid_data_q;
          main_last_d = skid_last_q;
          main_src_d  = skid_src_q;
        end
      end
      default: state_d = IDLE;
    endcase
    acc_en_d = (state_d != FULL);
    valid_d  = (state_d != IDLE);
  end

  always_comb begin
    last_grant_d = last_grant_q;
`ifdef ARB_PKT_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      lock_d     = !in_last;
      lock_idx_d = grant_idx;
      if (in_last) last_grant_d = grant_idx;
    end
`else
    if (accept) last_grant_d = grant_idx;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      acc_en_q     <= 1'b1;
      valid_q      <= 1'b0;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      main_src_q   <= '0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_src_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_en_q     <= acc_en_d;
      valid_q      <= valid_d;
      last_grant_q <= last_grant_d;
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      main_src_q   <= main_src_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_src_q   <= skid_src_d;
    end
  end

`ifdef ARB_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`endif

  assign m_valid = valid_q;
  assign m_data  = main_data_q;
  assign m_last  = main_last_q;
  assign m_src   = main_src_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter against a queue-level occupancy/round-robin model.
module tb_stream_rr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int WORD_WIDTH = 8;
  localparam int SRC_W      = $clog2(NUM_REQ);

  logic                          clk = 1'b0;
  logic                          rstn = 1'b0;
  logic [NUM_REQ-1:0]            s_valid;
  logic [NUM_REQ-1:0]            s_ready;
  logic [NUM_REQ*WORD_WIDTH-1:0] s_data;
  logic [NUM_REQ-1:0]            s_last;
  logic                          m_valid;
  logic                          m_ready;
  logic [WORD_WIDTH-1:0]         m_data;
  logic                          m_last;
  logic [SRC_W-1:0]              m_src;

  stream_rr_arbiter #(.NUM_REQ(NUM_REQ), .WORD_WIDTH(WORD_WIDTH)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_src(m_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic                  last;
    logic [SRC_W-1:0]      src;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: beats held by the arbiter, priority pointer, packet lock.
  int occ;
  int last_g;
  bit locked;
  int lock_idx;
  int accepted;
  bit use_ctr;
  logic [WORD_WIDTH-1:0] word [NUM_REQ];
  logic                  lastw[NUM_REQ];
  logic [WORD_WIDTH-1:0] ctr  [NUM_REQ];

  always_comb begin
    s_data = '0;
    s_last = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_data[i*WORD_WIDTH +: WORD_WIDTH] = word[i];
      s_last[i] = lastw[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    occ = 0;
    last_g = NUM_REQ - 1;
    locked = 0;
    lock_idx = 0;
    accepted = -1;
    exp_q.delete();
  endtask

  // Which requester the arbiter must take this cycle, or -1.
  function automatic int pick(input logic [NUM_REQ-1:0] v);
    if (occ >= 2) return -1;
`ifdef ARB_PKT_LOCK_EN
    if (locked) return v[lock_idx] ? lock_idx : -1;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last_g + k) % NUM_REQ]) return (last_g + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic step_check();
    int p;
    logic [NUM_REQ-1:0] exp_rdy;
    bit out;
    @(negedge clk);
    p = pick(s_valid);
    exp_rdy = (p >= 0) ? (NUM_REQ'(1) << p) : '0;
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
    chk("m_valid", 32'(m_valid), 32'(occ > 0));
    out = (occ > 0) && m_ready;
    if (p >= 0) begin
      exp_q.push_back({word[p], lastw[p], SRC_W'(p)});
`ifdef ARB_PKT_LOCK_EN
      locked = !lastw[p];
      lock_idx = p;
      if (lastw[p]) last_g = p;
`else
      last_g = p;
`endif
    end
    occ = occ + ((p >= 0) ? 1 : 0) - (out ? 1 : 0);
    accepted = p;
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] vmask, input int vpct, input int rpct,
                       input int lpct);
    @(posedge clk);
    #1;
    if (accepted >= 0) begin
      if (use_ctr) begin
        word[accepted] = ctr[accepted];
        ctr[accepted]  = ctr[accepted] + 8'd1;
      end else begin
        word[accepted] = WORD_WIDTH'($urandom);
      end
      lastw[accepted] = ($urandom_range(99) < lpct);
    end
    for (int i = 0; i < NUM_REQ; i++)
      s_valid[i] = vmask[i] && ($urandom_range(99) < vpct);
    m_ready = ($urandom_range(99) < rpct);
  endtask

  task automatic cycle(input logic [NUM_REQ-1:0] vmask, input int vpct, input int rpct,
                       input int lpct);
    step_check();
    drive(vmask, vpct, rpct, lpct);
  endtask

  // Monitor: every delivered beat must be the oldest expected one.
  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      beat_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat: got unexpected beat data %0h src %0d, expected none",
                 m_data, m_src);
      end else begin
        e = exp_q.pop_front();
        if ({m_data, m_last, m_src} !== e) begin
          errors++;
          $display("FAIL out_beat: got data %0h last %0b src %0d expected data %0h last %0b src %0d",
                   m_data, m_last, m_src, e.data, e.last, e.src);
        end
      end
    end
  end

  initial begin
    use_ctr = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      word[i]  = WORD_WIDTH'($urandom);
      lastw[i] = 1'b1;
      ctr[i]   = '0;
    end
    s_valid = '1;
    m_ready = 1'b1;
    rstn    = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data",  32'(m_data),  0);
    chk("rst_m_last",  32'(m_last),  0);
    chk("rst_m_src",   32'(m_src),   0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // All requesters valid, full throughput: sources rotate 0,1,2,3,...
    repeat (8) cycle('1, 100, 100, 100);
    repeat (4) cycle('0, 0, 100, 100);

    // Requester 1 streams a counter with three cycles of backpressure.
    use_ctr = 1;
    ctr[1]   = 8'h12;
    word[1]  = 8'h11;
    lastw[1] = 1'b1;
    s_valid  = 4'b0010;
    m_ready  = 1'b0;
    repeat (2) cycle(4'b0010, 100, 0, 100);
    cycle(4'b0010, 100, 100, 100);
    repeat (3) cycle(4'b0010, 100, 100, 100);
    repeat (4) cycle('0, 0, 100, 100);
    use_ctr = 0;

    // Randomized traffic with mixed valid density, backpressure and packet ends.
    repeat (300) cycle('1, 60, 70, 50);
    repeat (200) cycle(4'b0101, 90, 40, 30);
    repeat (200) cycle('1, 30, 100, 50);

    // Fill both output registers, then reset asynchronously.
    repeat (5) cycle('1, 100, 0, 60);
    rstn = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_s_ready", 32'(s_ready), 0);
    chk("midrst_m_data",  32'(m_data),  0);
    model_reset();
    s_valid = '1;
    m_ready = 1'b1;
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (6) cycle('1, 100, 100, 100);
    repeat (200) cycle('1, 70, 60, 40);

    repeat (8) cycle('0, 0, 100, 100);
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
